imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core.
- Receives a byte stream, for example from a UART receiver, over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory starting at word address 0.
- Holds the core in reset until the programme image is fully loaded, then releases it.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, instruction-memory capacity in words. Must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte. A byte transfers on a cycle with rx_valid & rx_ready.
- restart  in  1  one-cycle pulse; re-runs the load from DONE or ERR.
- imem_we  out  1  instruction-memory write strobe, one cycle wide.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  reset to the core; high while loading.
- boot_done  out  1  load completed successfully; level signal.
- boot_err  out  1  load aborted; level signal.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - state = HDR_LO
  - cpu_reset = 1
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - boot_done = 0, boot_err = 0
  - all counters = 0
- Frame format:
  - 2-byte word count N, little-endian.
  - Then 4*N payload bytes; each word is sent LSB first.
  - Then the optional checksum byte (see Optional Feature).
- rx_ready = 1 in HDR_LO, HDR_HI, DATA and CSUM; 0 in DONE and ERR. It is combinational from state only.
- State HDR_LO: on transfer, latch N[7:0] and go to HDR_HI.
- State HDR_HI: on transfer, latch N[15:8] and evaluate the full N:
  - N == 0 → DONE directly; no memory writes.
  - N > DEPTH → ERR.
  - Otherwise → DATA; clear word counter wcnt and byte counter bcnt.
- State DATA:
  - Each transfer shifts the byte into a 32-bit assembly register at lane bcnt; bcnt is 2 bits and wraps.
  - On the transfer with bcnt == 3, the next cycle has imem_we = 1, imem_addr = wcnt, imem_wdata = the assembled word. wcnt then increments.
  - Registered outputs give a write latency of 1 cycle after the 4th byte.
  - If that word was number N-1: go to CSUM when the feature is enabled, otherwise DONE. The state change happens on the same edge as the imem_we assertion.
- Stalls: rx_valid low in any state holds all state. Gaps between bytes are unlimited.
- State DONE:
  - boot_done = 1.
  - cpu_reset falls one cycle after entering DONE, so the final imem write has already completed before the core leaves reset.
- State ERR: boot_err = 1, cpu_reset stays 1.
- restart in DONE or ERR:
  - Return to HDR_LO; clear the flags and counters.
  - cpu_reset = 1 on the next edge.
- restart in any other state is ignored.
- Reset mid-load: the partial image stays in memory and the load restarts from the header.
- restart together with rx_valid: restart has priority, and no byte is accepted that cycle because rx_ready is 0 in DONE/ERR.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Enabled:
  - A running 8-bit XOR accumulates every payload byte.
  - State CSUM accepts one byte: if it equals the accumulator → DONE; otherwise → ERR.
  - The words already written remain in memory, but the core is never released.
- Disabled: no CSUM state and no accumulator; the last payload word leads directly to DONE.

Decomposition:
- Shared package `boot_pkg`:
  - state enum: HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR
  - header width constant HDR_BYTES = 2
  - byte-lane width constant
- Sub-module `boot_word_assembler`:
  - handles byte-lane shifting, the bcnt counter and the word-complete strobe
  - the FSM and write registers stay in the top level

Test Plan:
- Header 0x02,0x00; payload 13 05 00 00, 93 05 10 00 → imem writes addr0=0x00000513, addr1=0x00100593; boot_done = 1; cpu_reset falls 1 cycle after DONE.
- Header 0x00,0x00 → zero imem_we pulses; DONE on the edge after the second byte.
- Header N = DEPTH+1 (0x01,0x01 with DEPTH = 256) → ERR; boot_err = 1; rx_ready = 0; cpu_reset stays 1.
- One-word frame with rx_valid toggling every other cycle → the same single write 1 cycle after the 4th accepted byte; no duplicate or dropped bytes.
- BOOT_CHECKSUM_EN, one word AA BB CC DD with checksum 0x00 → DONE; the same frame with checksum 0x01 → ERR after the write to addr0.
- Reset asserted after 5 payload bytes, then a restart frame → the new image loads from addr 0; pulse restart from DONE → cpu_reset re-asserts the next cycle.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state codes,
// header geometry and byte-lane sizing.
package boot_pkg;

    localparam int HDR_BYTES = 2;
    localparam int LANE_W    = 8;
    localparam int LANES     = 4;
    localparam int HDR_W     = HDR_BYTES * LANE_W;
    localparam int WORD_W    = LANES * LANE_W;
    localparam int STATE_W   = 3;

    typedef logic [STATE_W-1:0] boot_state_t;

    localparam boot_state_t HDR_LO = 3'd0;
    localparam boot_state_t HDR_HI = 3'd1;
    localparam boot_state_t DATA   = 3'd2;
    localparam boot_state_t CSUM   = 3'd3;
    localparam boot_state_t DONE   = 3'd4;
    localparam boot_state_t ERR    = 3'd5;

endpackage

// File: rtl/boot_word_assembler.sv
// Collects little-endian bytes into a 32-bit word; flags the byte that completes
// a word and presents the full word (including that byte) combinationally.
module boot_word_assembler
    import boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [LANE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [1:0] bcnt_q;
    logic [1:0] bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (clear_i) begin
            bcnt_d = 2'd0;
        end else if (byte_valid_i) begin
            bcnt_d = bcnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            bcnt_q <= 2'd0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign word_done_o = byte_valid_i && (bcnt_q == 2'd3);

    // The completing byte bypasses its lane register so the word is whole on that cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_q;
            logic              hit;

            assign hit = byte_valid_i && (bcnt_q == 2'(gi));

            always_ff @(posedge clk or posedge rst_i) begin
                if (rst_i) begin
                    lane_q <= '0;
                end else if (hit) begin
                    lane_q <= byte_i;
                end
            end

            assign word_o[gi*LANE_W +: LANE_W] = hit ? byte_i : lane_q;
        end
    endgenerate

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core
// in reset until done. Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic              boot_err
);

    boot_state_t       state_q,      state_d;
    logic [HDR_W-1:0]  n_q,          n_d;
    logic [ADDR_W-1:0] wcnt_q,       wcnt_d;
    logic              cpu_reset_q,  cpu_reset_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q,       csum_d;
`endif

    logic              xfer;
    logic              asm_valid;
    logic              asm_clear;
    logic [WORD_W-1:0] asm_word;
    logic              asm_done;
    logic [HDR_W-1:0]  n_full;
    logic              last_word;

    assign rx_ready  = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                       (state_q == DATA)   || (state_q == CSUM);
    assign xfer      = rx_valid && rx_ready;
    assign asm_valid = xfer && (state_q == DATA);
    assign n_full    = {rx_data, n_q[7:0]};
    assign last_word = (HDR_W'(wcnt_q) == (n_q - 1'b1));

    boot_word_assembler u_asm (
        .clk          (clk),
        .rst_i        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .word_o       (asm_word),
        .word_done_o  (asm_done)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        asm_clear    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            HDR_LO: begin
                if (xfer) begin
                    n_d[7:0] = rx_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    n_d = n_full;
                    if (n_full == '0) begin
                        state_d = DONE;
                    end else if (32'(n_full) > 32'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d   = DATA;
                        wcnt_d    = '0;
                        asm_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum_d    = 8'd0;
`endif
                    end
                end
            end
            DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                end
`endif
                if (asm_done) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = wcnt_q;
                    imem_wdata_d = asm_word;
                    wcnt_d       = wcnt_q + 1'b1;
                    if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (restart) begin
                    state_d   = HDR_LO;
                    n_d       = '0;
                    wcnt_d    = '0;
                    asm_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            default: state_d = HDR_LO;
        endcase
    end

    // Released only after a full cycle in DONE so the last write lands first.
    assign cpu_reset_d = !((state_q == DONE) && !restart);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HDR_LO;
            n_q          <= '0;
            wcnt_q       <= '0;
            cpu_reset_q  <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            cpu_reset_q  <= cpu_reset_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign boot_done  = (state_q == DONE);
    assign boot_err   = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames built from word lists, writes
// captured and compared against the expected sequential image.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              boot_done;
    logic              boot_err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    int          cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    logic [31:0] frame_words[$];
    int          last_acc;
    int          last_data_acc;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            cap_addr.push_back(int'(imem_addr));
            cap_data.push_back(imem_wdata);
            cap_cyc.push_back(cyc);
        end
    end

    function automatic int gap_of(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < gap; i++) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            ok = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
            if (ok) break;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        last_acc = cyc;
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL byte_accept: byte %02h not taken, rx_ready=%b required 1", b, rx_ready);
        end
    endtask

    task automatic send_frame(input int n, input int mode, input logic [7:0] csum_flip);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        send_byte(n[7:0], gap_of(mode));
        send_byte(n[15:8], gap_of(mode));
        if (n == 0 || n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = frame_words[i][8*j +: 8];
                x = x ^ b;
                send_byte(b, gap_of(mode));
            end
        end
        last_data_acc = last_acc;
`ifdef BOOT_CHECKSUM_EN
        send_byte(x ^ csum_flip, gap_of(mode));
`else
        x = csum_flip;
`endif
    endtask

    task automatic expect_writes(input int n);
        repeat (2) @(negedge clk);
        nvec++;
        if (cap_addr.size() != n) begin
            nerr++;
            $display("FAIL write_count: got %0d writes, required %0d", cap_addr.size(), n);
        end
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            nvec++;
            if (cap_addr[i] !== i || cap_data[i] !== frame_words[i]) begin
                nerr++;
                $display("FAIL write_%0d: got addr %0d data %08h, required addr %0d data %08h",
                         i, cap_addr[i], cap_data[i], i, frame_words[i]);
            end
        end
        if (n > 0 && cap_cyc.size() == n) begin
            nvec++;
            if (cap_cyc[n-1] !== last_data_acc) begin
                nerr++;
                $display("FAIL write_latency: write seen in cycle %0d, required %0d",
                         cap_cyc[n-1], last_data_acc);
            end
        end
        $display("frame n=%0d: %0d writes captured", n, cap_addr.size());
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic do_restart(input bit from_done);
        @(negedge clk);
        nvec++;
        if (boot_done !== from_done || boot_err !== !from_done || cpu_reset !== !from_done) begin
            nerr++;
            $display("FAIL pre_restart: done=%b err=%b cpu_reset=%b, required %b %b %b",
                     boot_done, boot_err, cpu_reset, from_done, !from_done, !from_done);
        end
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        nvec++;
        if (cpu_reset !== 1'b1 || boot_done !== 1'b0 || boot_err !== 1'b0 || rx_ready !== 1'b1) begin
            nerr++;
            $display("FAIL restart: cpu_reset=%b done=%b err=%b ready=%b, required 1 0 0 1",
                     cpu_reset, boot_done, boot_err, rx_ready);
        end
        $display("restart from %s", from_done ? "DONE" : "ERR");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++;
        if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 ||
            boot_done !== 1'b0 || boot_err !== 1'b0 || rx_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state: cpu_reset=%b we=%b addr=%0d wdata=%08h done=%b err=%b ready=%b",
                     cpu_reset, imem_we, imem_addr, imem_wdata, boot_done, boot_err, rx_ready);
        end
        $display("reset state checked");
    endtask

    task automatic test_directed();
        frame_words = {32'h00000513, 32'h00100593};
        send_frame(2, 0, 8'h00);
        @(negedge clk);
        nvec++;
        if (boot_done !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin
            nerr++;
            $display("FAIL done_entry: done=%b cpu_reset=%b ready=%b, required 1 1 0",
                     boot_done, cpu_reset, rx_ready);
        end
        @(negedge clk);
        nvec++;
        if (cpu_reset !== 1'b0) begin
            nerr++;
            $display("FAIL cpu_release: cpu_reset=%b, required 0", cpu_reset);
        end
        expect_writes(2);
        do_restart(1'b1);
    endtask

    task automatic test_zero();
        frame_words.delete();
        send_frame(0, 0, 8'h00);
        @(negedge clk);
        nvec++;
        if (boot_done !== 1'b1) begin
            nerr++;
            $display("FAIL zero_done: boot_done=%b, required 1", boot_done);
        end
        expect_writes(0);
        do_restart(1'b1);
    endtask

    task automatic test_oversize();
        frame_words.delete();
        send_frame(DEPTH + 1, 0, 8'h00);
        @(negedge clk);
        nvec++;
        if (boot_err !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            nerr++;
            $display("FAIL oversize: err=%b ready=%b cpu_reset=%b, required 1 0 1",
                     boot_err, rx_ready, cpu_reset);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (cpu_reset !== 1'b1 || boot_done !== 1'b0) begin
            nerr++;
            $display("FAIL err_hold: cpu_reset=%b done=%b, required 1 0", cpu_reset, boot_done);
        end
        expect_writes(0);
        do_restart(1'b0);
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 7; f++) begin
            n = (f == 6) ? DEPTH : int'($urandom_range(1, 6));
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            send_frame(n, (f == 6) ? 0 : f % 3, 8'h00);
            @(negedge clk);
            nvec++;
            if (boot_done !== 1'b1 || boot_err !== 1'b0) begin
                nerr++;
                $display("FAIL frame_%0d_done: done=%b err=%b, required 1 0", f, boot_done, boot_err);
            end
            expect_writes(n);
            do_restart(1'b1);
        end
    endtask

    task automatic test_reset_mid();
        frame_words = {32'h11223344, 32'h55667788, 32'h99AABBCC};
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 5; k++) send_byte(frame_words[k/4][8*(k%4) +: 8], 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++;
        if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
            nerr++;
            $display("FAIL async_reset: cpu_reset=%b we=%b addr=%0d wdata=%08h, required 1 0 0 0",
                     cpu_reset, imem_we, imem_addr, imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        frame_words = {$urandom, $urandom};
        send_frame(2, 2, 8'h00);
        expect_writes(2);
        do_restart(1'b1);
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        frame_words = {32'hDDCCBBAA};
        send_frame(1, 0, 8'h00);
        @(negedge clk);
        nvec++;
        if (boot_done !== 1'b1) begin
            nerr++;
            $display("FAIL csum_good: boot_done=%b, required 1", boot_done);
        end
        expect_writes(1);
        do_restart(1'b1);
        send_frame(1, 0, 8'h01);
        @(negedge clk);
        nvec++;
        if (boot_err !== 1'b1 || cpu_reset !== 1'b1) begin
            nerr++;
            $display("FAIL csum_bad: err=%b cpu_reset=%b, required 1 1", boot_err, cpu_reset);
        end
        expect_writes(1);
        do_restart(1'b0);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        test_reset();
        test_directed();
        test_zero();
        test_oversize();
        test_random_frames();
        test_reset_mid();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
